// File: rtl/bg_scaler.sv
// Background scaler: maps the VGA raster onto a SRC_W x SRC_H image, either stretched to
// the full screen or tiled 1:1 with a per-frame scroll, through a fixed 3-cycle pipeline.
module bg_scaler #(
  parameter int SRC_W  = 400,
  parameter int SRC_H  = 300,
  parameter int SCR_W  = 640,
  parameter int SCR_H  = 480,
  parameter int IDX_W  = 4,
  parameter int ADDR_W = $clog2(SRC_W * SRC_H)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              mode,
  input  logic [9:0]        scroll_x,
  input  logic [9:0]        scroll_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_index,
  output logic              pix_valid
);

  typedef enum logic {MODE_STRETCH = 1'b0, MODE_TILE = 1'b1} mode_e;

  localparam logic [10:0]       SRC_W_C  = 11'(SRC_W);
  localparam logic [10:0]       SRC_H_C  = 11'(SRC_H);
  localparam logic [10:0]       SCR_W_C  = 11'(SCR_W);
  localparam logic [10:0]       SCR_H_C  = 11'(SCR_H);
  localparam logic [9:0]        U_LAST   = 10'(SRC_W - 1);
  localparam logic [9:0]        V_LAST   = 10'(SRC_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

  mode_e             r_mode, w_mode_nxt;
  logic [9:0]        r_sx, w_sx_nxt, r_sy, w_sy_nxt;
  logic [9:0]        r_u, w_u_nxt, r_v, w_v_nxt;
  logic [9:0]        r_hacc, w_hacc_nxt, r_vacc, w_vacc_nxt;
  logic [ADDR_W-1:0] r_row_base, w_row_base_nxt;
  logic              r_synced, w_synced_nxt;
  logic              r_vld1, r_vld2, r_vld3;

  logic              w_frame_start, w_line_start, w_in_range;
  logic [9:0]        w_sx_in, w_sy_in;
  logic [10:0]       w_hsum, w_vsum;
  logic [ADDR_W-1:0] w_row0;

  assign w_frame_start = (DrawX == '0) && (DrawY == '0);
  assign w_line_start  = (DrawX == '0) && (DrawY != '0);
  assign w_in_range    = ({1'b0, DrawX} < SCR_W_C) && ({1'b0, DrawY} < SCR_H_C);
  assign w_sx_in       = ({1'b0, scroll_x} < SRC_W_C) ? scroll_x : '0;
  assign w_sy_in       = ({1'b0, scroll_y} < SRC_H_C) ? scroll_y : '0;
  assign w_row0        = ADDR_W'(32'(w_sy_in) * SRC_W);
  assign w_hsum        = {1'b0, r_hacc} + SRC_W_C;
  assign w_vsum        = {1'b0, r_vacc} + SRC_H_C;

  always_comb begin
    w_mode_nxt     = r_mode;
    w_sx_nxt       = r_sx;
    w_sy_nxt       = r_sy;
    w_u_nxt        = r_u;
    w_v_nxt        = r_v;
    w_hacc_nxt     = r_hacc;
    w_vacc_nxt     = r_vacc;
    w_row_base_nxt = r_row_base;
    w_synced_nxt   = r_synced;
    if (w_frame_start) begin
      w_mode_nxt   = mode_e'(mode);
      w_sx_nxt     = w_sx_in;
      w_sy_nxt     = w_sy_in;
      w_synced_nxt = 1'b1;
      w_hacc_nxt   = '0;
      w_vacc_nxt   = '0;
      if (mode_e'(mode) == MODE_TILE) begin
        w_u_nxt        = w_sx_in;
        w_v_nxt        = w_sy_in;
        w_row_base_nxt = w_row0;
      end else begin
        w_u_nxt        = '0;
        w_v_nxt        = '0;
        w_row_base_nxt = '0;
      end
    // Counters stay frozen until the first frame start so the address never leaves the image.
    end else if (r_synced && w_in_range) begin
      if (w_line_start) begin
        w_hacc_nxt = '0;
        if (r_mode == MODE_TILE) begin
          w_u_nxt = r_sx;
          if (r_v == V_LAST) begin
            w_v_nxt        = '0;
            w_row_base_nxt = '0;
          end else begin
            w_v_nxt        = r_v + 10'd1;
            w_row_base_nxt = r_row_base + ROW_STEP;
          end
        end else begin
          w_u_nxt = '0;
          if (w_vsum >= SCR_H_C) begin
            w_vacc_nxt     = 10'(w_vsum - SCR_H_C);
            w_v_nxt        = r_v + 10'd1;
            w_row_base_nxt = r_row_base + ROW_STEP;
          end else begin
            w_vacc_nxt = w_vsum[9:0];
          end
        end
      end else begin
        if (r_mode == MODE_TILE) begin
          w_u_nxt = (r_u == U_LAST) ? '0 : r_u + 10'd1;
        end else if (w_hsum >= SCR_W_C) begin
          w_hacc_nxt = 10'(w_hsum - SCR_W_C);
          w_u_nxt    = r_u + 10'd1;
        end else begin
          w_hacc_nxt = w_hsum[9:0];
        end
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_mode     <= MODE_STRETCH;
      r_sx       <= '0;
      r_sy       <= '0;
      r_u        <= '0;
      r_v        <= '0;
      r_hacc     <= '0;
      r_vacc     <= '0;
      r_row_base <= '0;
      r_synced   <= 1'b0;
      r_vld1     <= 1'b0;
      r_vld2     <= 1'b0;
      r_vld3     <= 1'b0;
      rom_addr   <= '0;
      pix_index  <= '0;
      pix_valid  <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_sx       <= w_sx_nxt;
      r_sy       <= w_sy_nxt;
      r_u        <= w_u_nxt;
      r_v        <= w_v_nxt;
      r_hacc     <= w_hacc_nxt;
      r_vacc     <= w_vacc_nxt;
      r_row_base <= w_row_base_nxt;
      r_synced   <= w_synced_nxt;
      r_vld1     <= blank && w_synced_nxt && w_in_range;
      r_vld2     <= r_vld1;
      r_vld3     <= r_vld2;
      rom_addr   <= r_row_base + ADDR_W'(r_u);
      pix_index  <= r_vld3 ? rom_q : '0;
      pix_valid  <= r_vld3;
    end
  end

endmodule

// File: tb/tb_bg_scaler.sv
// Bench for bg_scaler: compressed raster frames with random blank/scroll/mode, checked against
// a floor/modulo reference of the texel mapping and a behavioural ROM.
module tb_bg_scaler;

  logic        vga_clk;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank, mode;
  logic [9:0]  scroll_x, scroll_y;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  pix_index;
  logic        pix_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit chk;
    bit valid;
    int addr;
    int x;
    int y;
  } ent_t;

  ent_t h[4];
  bit   m_synced;
  bit   m_mode;
  int   m_sx, m_sy;

  bg_scaler #(
    .SRC_W(400), .SRC_H(300), .SCR_W(640), .SCR_H(480), .IDX_W(4)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .mode(mode), .scroll_x(scroll_x), .scroll_y(scroll_y), .rom_addr(rom_addr),
    .rom_q(rom_q), .pix_index(pix_index), .pix_valid(pix_valid)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic [3:0] rom_fn(input logic [16:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {3'b000, a[16]};
  endfunction

  always @(posedge vga_clk) rom_q <= rom_fn(rom_addr);

  task automatic drive(input int x, input int y, input bit b);
    ent_t cur;
    int   u, v;
    logic [3:0] exp_idx;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    cur = '{chk: 1'b0, valid: 1'b0, addr: 0, x: x, y: y};
    if (reset) begin
      m_synced = 1'b0;
      m_mode   = 1'b0;
      m_sx     = 0;
      m_sy     = 0;
      for (int i = 0; i < 4; i++) h[i] = cur;
    end else begin
      if (x == 0 && y == 0) begin
        m_synced = 1'b1;
        m_mode   = mode;
        m_sx     = (int'(scroll_x) < 400) ? int'(scroll_x) : 0;
        m_sy     = (int'(scroll_y) < 300) ? int'(scroll_y) : 0;
      end
      if (m_synced && x < 640 && y < 480) begin
        u = m_mode ? (m_sx + x) % 400 : (x * 400) / 640;
        v = m_mode ? (m_sy + y) % 300 : (y * 300) / 480;
        cur.chk  = 1'b1;
        cur.addr = v * 400 + u;
      end
      cur.valid = b && cur.chk;
    end
    @(posedge vga_clk);
    #1;
    h[3] = h[2];
    h[2] = h[1];
    h[1] = h[0];
    h[0] = cur;

    checks++;
    assert (rom_addr < 17'd120000) else begin
      errors++;
      $error("FAIL addr_range x=%0d y=%0d rom_addr=%0d required below 120000", x, y, rom_addr);
    end
    if (reset) begin
      checks++;
      assert (rom_addr === 17'd0 && pix_valid === 1'b0 && pix_index === 4'd0) else begin
        errors++;
        $error("FAIL reset_state rom_addr=%0d pix_valid=%0b pix_index=%0d required 0/0/0",
               rom_addr, pix_valid, pix_index);
      end
    end
    if (h[1].chk) begin
      checks++;
      assert (rom_addr === 17'(h[1].addr)) else begin
        errors++;
        $error("FAIL rom_addr x=%0d y=%0d got=%0d exp=%0d", h[1].x, h[1].y, rom_addr, h[1].addr);
      end
    end
    exp_idx = h[3].valid ? rom_fn(17'(h[3].addr)) : 4'd0;
    checks++;
    assert (pix_valid === h[3].valid && pix_index === exp_idx) else begin
      errors++;
      $error("FAIL pixel x=%0d y=%0d valid got=%0b exp=%0b index got=%0d exp=%0d",
             h[3].x, h[3].y, pix_valid, h[3].valid, pix_index, exp_idx);
    end
  endtask

  task automatic line(input int y, input int n, input int rst_row);
    for (int x = 0; x < n; x++) begin
      reset = (y == rst_row) && (x == 5 || x == 6);
      drive(x, y, ($urandom % 8) != 0);
    end
    reset = 1'b0;
  endtask

  task automatic frame(input bit md, input int sx, input int sy, input int rst_row);
    for (int y = 0; y < 500; y++) begin
      int n;
      if (y == 0) begin
        mode     = md;
        scroll_x = 10'(sx);
        scroll_y = 10'(sy);
      end else begin
        mode     = 1'($urandom);
        scroll_x = 10'($urandom);
        scroll_y = 10'($urandom);
      end
      n = (y < 3 || y == 479 || y % 100 == 50 || y == rst_row) ? 660 : 1 + int'($urandom % 6);
      line(y, n, rst_row);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) h[i] = '{chk: 1'b0, valid: 1'b0, addr: 0, x: 0, y: 0};
    m_synced = 1'b0;
    m_mode   = 1'b0;
    m_sx     = 0;
    m_sy     = 0;
    reset    = 1'b1;
    mode     = 1'b1;
    scroll_x = 10'd17;
    scroll_y = 10'd9;
    blank    = 1'b1;
    DrawX    = '0;
    DrawY    = '0;
    #1;
    for (int i = 0; i < 3; i++) drive(i + 3, 470, 1'b1);
    reset = 1'b0;

    for (int y = 470; y < 500; y++) line(y, (y == 475) ? 660 : 3, -1);

    frame(1'b0, 123, 45, -1);
    frame(1'b1, 395, 299, -1);
    frame(1'b1, 700, 37, -1);
    frame(1'b0, 5, 5, 200);
    frame(1'b1, int'($urandom_range(0, 399)), 1000, -1);
    frame(1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), -1);
    frame(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), -1);
    mode = 1'b1;
    scroll_x = 10'd0;
    scroll_y = 10'd0;
    line(0, 6, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bg_scaler.md
BG_SCALER -- requirements
Module: bg_scaler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SRC_W, 400, source image width in texels; SHALL satisfy 1 <= SRC_W <= SCR_W.
- SRC_H, 300, source image height in texels; SHALL satisfy 1 <= SRC_H <= SCR_H.
- SCR_W, 640, active screen width in pixels.
- SCR_H, 480, active screen height in pixels.
- IDX_W, 4, palette index width.
- ADDR_W, $clog2(SRC_W*SRC_H) = 17, ROM address width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- vga_clk, in, 1, pixel clock; all state is clocked on its rising edge.
- reset, in, 1, asynchronous active-high reset.
- DrawX, in, 10, current pixel column; advances by one each vga_clk.
- DrawY, in, 10, current pixel row.
- blank, in, 1, 1 = active display region.
- mode, in, 1, 0 = stretch source to full screen; 1 = 1:1 tiled with scroll.
- scroll_x, in, 10, tile-mode horizontal texel offset.
- scroll_y, in, 10, tile-mode vertical texel offset.
- rom_addr, out, ADDR_W, registered address to an external synchronous ROM with 1-cycle read latency.
- rom_q, in, IDX_W, ROM data, valid 1 cycle after rom_addr.
- pix_index, out, IDX_W, registered palette index for the pixel.
- pix_valid, out, 1, 1 = pix_index is a displayable pixel.

Function
REQ-003 A frame start SHALL occur on a cycle with DrawX==0 and DrawY==0; a line start SHALL occur on a cycle with DrawX==0 and DrawY!=0.
REQ-004 At frame start, mode, scroll_x and scroll_y SHALL be latched. Changes at any other time SHALL have no effect until the next frame start (no mid-frame tearing).
REQ-005 A latched scroll_x >= SRC_W SHALL be treated as 0; a latched scroll_y >= SRC_H SHALL be treated as 0.
REQ-006 Texel coordinates (u,v) SHALL be computed with incremental counters only. No divider SHALL be used. At most one multiplier SHALL be used, and only for the row base at frame start.
REQ-007 Stretch, horizontal: on a line or frame start, u=0 and hacc=0. On each other cycle, hacc += SRC_W; if the result >= SCR_W, subtract SCR_W and increment u. This SHALL give u = floor(DrawX*SRC_W/SCR_W).
REQ-008 Stretch, vertical: at frame start, v=0 and vacc=0. At each line start, vacc += SRC_H; if the result >= SCR_H, subtract SCR_H and increment v. This SHALL give v = floor(DrawY*SRC_H/SCR_H).
REQ-009 Tile, horizontal: on a line or frame start, u = scroll_x. On each other cycle, u increments and wraps from SRC_W-1 to 0.
REQ-010 Tile, vertical: at frame start, v = scroll_y. At each line start, v increments and wraps from SRC_H-1 to 0.
REQ-011 A row-base register SHALL track v*SRC_W. It is loaded at frame start and incremented by SRC_W when v increments (cleared to 0 on a tile wrap). rom_addr = row_base + u.
REQ-012 Pipeline: for DrawX/DrawY/blank sampled at edge k, rom_addr SHALL update at edge k+1 and rom_q is valid at edge k+2. pix_index SHALL equal that rom_q at edge k+3. Fixed latency is 3 cycles.
REQ-013 blank SHALL be delayed through a matching 3-stage pipeline. pix_valid = delayed blank AND synced AND (delayed DrawX < SCR_W) AND (delayed DrawY < SCR_H).
REQ-014 When pix_valid==0, pix_index SHALL be 0.
REQ-015 For DrawX >= SCR_W or DrawY >= SCR_H, the u/v counters SHALL hold. rom_addr may change but SHALL stay < SRC_W*SRC_H at all times.
REQ-016 The synced flag SHALL be cleared by reset and set at the first frame start. It SHALL remain 1 until the next reset.

Reset
REQ-017 While reset=1: rom_addr=0, pix_index=0, pix_valid=0, u=v=hacc=vacc=row_base=0, synced=0, latched mode=0, latched scrolls=0, and all pipeline stages cleared.
REQ-018 A reset mid-frame SHALL force pix_valid=0 from the asserting edge until 3 cycles after the first subsequent frame start. No partial-frame output SHALL occur.

Verification
REQ-019 Stretch, DrawX=639, DrawY=479 -> rom_addr=119999 one cycle later, and pix_index=rom_q 3 cycles after sampling.
REQ-020 Stretch, line y=2, x=0,1,2,3,4 -> u=0,0,1,1,2 and rom_addr=400,400,401,401,402 (v=1).
REQ-021 Tile, scroll_x=395, scroll_y=299, DrawY=1, x=0..5 -> rom_addr=395,396,397,398,399,0.
REQ-022 Tile, scroll_x=700 latched -> treated as 0; DrawY=0, x=0 -> rom_addr=scroll_y*400.
REQ-023 mode toggled 0->1 at DrawY=100 -> rest of frame stays stretch; tile addressing starts at the next frame start.
REQ-024 reset asserted at DrawY=200 for 2 cycles -> pix_valid=0 and pix_index=0 through end of frame; pix_valid rises 3 cycles after the next DrawX=0, DrawY=0 with blank=1.
